// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the touch-LCD game-flow controller: state encodings,
// button roles and the helper that locates one field of a packed button rectangle.
package game_flow_ctrl_pkg;

   typedef enum logic [1:0] {
      STATE_MENU  = 2'd0,
      STATE_GAME  = 2'd1,
      STATE_PAUSE = 2'd2,
      STATE_OVER  = 2'd3
   } gameState_t;

   // Buttons with a fixed role in the game flow; higher indices are user pulses only
   localparam int BTN_START = 0;
   localparam int BTN_PAUSE = 1;
   localparam int BTN_QUIT  = 2;

   // Field slots inside one packed rectangle {x0,y0,x1,y1}; y1 sits in the lowest bits
   localparam int FIELD_Y1 = 0;
   localparam int FIELD_X1 = 1;
   localparam int FIELD_Y0 = 2;
   localparam int FIELD_X0 = 3;

   // Bit offset of one rectangle field of button btnIdx, for a coordWidth-bit part-select
   function automatic int rectFieldLsb(input int btnIdx, input int field, input int coordWidth);
      return ((4 * btnIdx) + field) * coordWidth;
   endfunction

endpackage

// File: rtl/touch_btn_detect.sv
// Touch button detector: strict-bounds hit-test against N rectangles, lowest-index
// selection, and a hold counter that accepts a press after HOLD_CYCLES steady cycles.
// Each accepted press gives exactly one pulse until the finger lifts or moves.
module touch_btn_detect
   import game_flow_ctrl_pkg::*;
#(
   parameter int                         COORD_W     = 16,
   parameter int                         N_BTN       = 3,
   parameter logic [4*COORD_W*N_BTN-1:0] BTN_RECT    = '0,
   parameter int                         HOLD_CYCLES = 1_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_touchValid,
   input  logic [COORD_W-1:0] i_xCoord,
   input  logic [COORD_W-1:0] i_yCoord,
   output logic [N_BTN-1:0]   o_btnPress
);

   localparam int SEL_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
   localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   // True when lo < v < hi; done with widened subtraction so that degenerate
   // (all-zero) rectangles do not turn into constant comparisons
   function automatic logic strictlyBetween(input logic [COORD_W-1:0] v,
                                            input logic [COORD_W-1:0] lo,
                                            input logic [COORD_W-1:0] hi);
      logic [COORD_W+1:0] aboveLo;
      logic [COORD_W+1:0] belowHi;
      aboveLo = {2'b00, v}  - {2'b00, lo} - {{(COORD_W+1){1'b0}}, 1'b1};
      belowHi = {2'b00, hi} - {2'b00, v}  - {{(COORD_W+1){1'b0}}, 1'b1};
      return !aboveLo[COORD_W+1] && !belowHi[COORD_W+1];
   endfunction

   logic [N_BTN-1:0] w_hit;
   logic             w_anyHit;
   logic [SEL_W-1:0] w_sel;
   logic             w_same;
   logic             w_armedNow;
   logic [CNT_W-1:0] w_cntNow;
   logic             w_fire;
   logic [N_BTN-1:0] w_pressNext;

   logic             r_prevValid;
   logic [SEL_W-1:0] r_prevSel;
   logic [CNT_W-1:0] r_holdCnt;
   logic             r_armed;
   logic [N_BTN-1:0] r_press;

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_hit
      localparam logic [COORD_W-1:0] X0 = BTN_RECT[rectFieldLsb(gi, FIELD_X0, COORD_W) +: COORD_W];
      localparam logic [COORD_W-1:0] Y0 = BTN_RECT[rectFieldLsb(gi, FIELD_Y0, COORD_W) +: COORD_W];
      localparam logic [COORD_W-1:0] X1 = BTN_RECT[rectFieldLsb(gi, FIELD_X1, COORD_W) +: COORD_W];
      localparam logic [COORD_W-1:0] Y1 = BTN_RECT[rectFieldLsb(gi, FIELD_Y1, COORD_W) +: COORD_W];
      assign w_hit[gi] = i_touchValid
                         && strictlyBetween(i_xCoord, X0, X1)
                         && strictlyBetween(i_yCoord, Y0, Y1);
   end

   // Pick the lowest-index button under the finger so overlapping rectangles resolve predictably
   always_comb begin
      w_anyHit = |w_hit;
      w_sel    = '0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_sel = SEL_W'(i);
         end
      end
   end

   // A hold continues only if the same button was selected last cycle; anything else restarts it and re-arms
   always_comb begin
      w_same      = w_anyHit && r_prevValid && (w_sel == r_prevSel);
      w_armedNow  = w_same ? r_armed : 1'b1;
      w_cntNow    = w_same ? (r_holdCnt + CNT_W'(1)) : '0;
      w_fire      = w_anyHit && w_armedNow && (w_cntNow == CNT_LAST);
      w_pressNext = '0;
      for (int i = 0; i < N_BTN; i++) begin
         w_pressNext[i] = w_fire && (w_sel == SEL_W'(i));
      end
   end

   // Track the held button, count steady cycles and emit a single registered pulse per press
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prevValid <= 1'b0;
         r_prevSel   <= '0;
         r_holdCnt   <= '0;
         r_armed     <= 1'b0;
         r_press     <= '0;
      end else begin
         r_prevValid <= w_anyHit;
         r_prevSel   <= w_sel;
         r_holdCnt   <= (w_anyHit && w_armedNow && !w_fire) ? w_cntNow : '0;
         r_armed     <= w_armedNow && !w_fire;
         r_press     <= w_pressNext;
      end
   end

   assign o_btnPress = r_press;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: MENU/GAME/PAUSE/OVER state machine driven by debounced
// touch buttons, with a one-second prescaler and a round countdown timer.
// State changes land one cycle after the accepted button pulse.
module game_flow_ctrl
   import game_flow_ctrl_pkg::*;
#(
   parameter int                         COORD_W       = 16,
   parameter int                         N_BTN         = 3,
   parameter logic [4*COORD_W*N_BTN-1:0] BTN_RECT      = '0,
   parameter int                         HOLD_CYCLES   = 1_000_000,
   parameter int                         TICKS_PER_SEC = 50_000_000,
   parameter int                         GAME_SECS     = 60
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               touch_valid,
   input  logic [COORD_W-1:0] tp_x_coord,
   input  logic [COORD_W-1:0] tp_y_coord,
   input  logic               game_end_req,
   output logic [1:0]         state,
   output logic [N_BTN-1:0]   btn_press,
   output logic               round_start,
   output logic               sec_tick,
   output logic [7:0]         timer
);

   localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
   localparam logic [7:0] TIMER_LOAD = 8'(GAME_SECS);

   logic [N_BTN-1:0]   w_press;

   gameState_t         r_state;
   logic [PRESC_W-1:0] r_presc;
   logic [7:0]         r_timer;
   logic               r_roundStart;
   logic               r_secTick;

   touch_btn_detect #(
      .COORD_W     (COORD_W),
      .N_BTN       (N_BTN),
      .BTN_RECT    (BTN_RECT),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_btnDetect (
      .clk          (clk),
      .rst          (rst),
      .i_touchValid (touch_valid),
      .i_xCoord     (tp_x_coord),
      .i_yCoord     (tp_y_coord),
      .o_btnPress   (w_press)
   );

   // Game flow: button-driven state changes, second prescaler and countdown, with one-cycle event pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= STATE_MENU;
         r_presc      <= '0;
         r_timer      <= TIMER_LOAD;
         r_roundStart <= 1'b0;
         r_secTick    <= 1'b0;
      end else begin
         r_roundStart <= 1'b0;
         r_secTick    <= 1'b0;
         case (r_state)
            STATE_MENU: begin
               if (w_press[BTN_START]) begin
                  r_state      <= STATE_GAME;
                  r_timer      <= TIMER_LOAD;
                  r_presc      <= '0;
                  r_roundStart <= 1'b1;
               end
            end
            STATE_GAME: begin
               if (game_end_req) begin
                  r_state <= STATE_OVER;
               end else if (w_press[BTN_PAUSE]) begin
                  r_state <= STATE_PAUSE;
               end else if (r_presc == PRESC_LAST) begin
                  r_presc   <= '0;
                  r_secTick <= 1'b1;
                  if (r_timer <= 8'd1) begin
                     r_timer <= 8'd0;
                     r_state <= STATE_OVER;
                  end else begin
                     r_timer <= r_timer - 8'd1;
                  end
               end else begin
                  r_presc <= r_presc + PRESC_W'(1);
               end
            end
            STATE_PAUSE: begin
               if (w_press[BTN_PAUSE]) begin
                  r_state <= STATE_GAME;
               end else if (w_press[BTN_QUIT]) begin
                  r_state <= STATE_MENU;
                  r_timer <= TIMER_LOAD;
               end
            end
            STATE_OVER: begin
               if (w_press[BTN_START]) begin
                  r_state      <= STATE_GAME;
                  r_timer      <= TIMER_LOAD;
                  r_presc      <= '0;
                  r_roundStart <= 1'b1;
               end else if (w_press[BTN_QUIT]) begin
                  r_state <= STATE_MENU;
                  r_timer <= TIMER_LOAD;
               end
            end
            default: begin
               r_state <= STATE_MENU;
            end
         endcase
      end
   end

   assign state       = r_state;
   assign btn_press   = w_press;
   assign round_start = r_roundStart;
   assign sec_tick    = r_secTick;
   assign timer       = r_timer;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Parametrised game-flow controller for the touch-LCD game family. It replaces the fixed single start-button hit-test and the 3-state menu/game/over flow with N touch buttons, a debounced press detector, a PAUSE state and an internal round countdown timer. It sits between the touch front-end (coordinates plus touch_valid) and the game/display logic, and supplies them with state, the timer and one-cycle event pulses.

Parameters:
COORD_W, 16, touch coordinate width
N_BTN, 3, number of touch buttons (min 3). Btn0 = start/restart, btn1 = pause/resume, btn2 = quit-to-menu, btn3+ = user pulses only
BTN_RECT, {N_BTN{64'h0}}, packed per-button rectangle {x0,y0,x1,y1}, each COORD_W bits. Button i is at bits [4*COORD_W*(i+1)-1 : 4*COORD_W*i]
HOLD_CYCLES, 1_000_000, consecutive cycles inside one button before a press is accepted
TICKS_PER_SEC, 50_000_000, clk cycles per game second
GAME_SECS, 60, round length in seconds (1..255)

Ports:
clk  in  1  system clock (50 MHz domain)
rst  in  1  synchronous reset, active-high
touch_valid  in  1  touch controller reports an active contact
tp_x_coord  in  COORD_W  touch X coordinate
tp_y_coord  in  COORD_W  touch Y coordinate
game_end_req  in  1  game logic requests early end (e.g. lives exhausted); level-sensitive
state  out  2  MENU=0, GAME=1, PAUSE=2, OVER=3
btn_press  out  N_BTN  one-cycle pulse per accepted press
round_start  out  1  one-cycle pulse on every entry to GAME from MENU or OVER
sec_tick  out  1  one-cycle pulse on each elapsed game second
timer  out  8  seconds remaining

Behaviour:
- Reset values: state=MENU, timer=GAME_SECS, btn_press=0, round_start=0, sec_tick=0. Reset also clears the hold counter, prescaler and armed flags. Reset mid-round aborts the round to MENU.
- Hit-test (combinational): hit[i] = touch_valid & x0<x<x1 & y0<y<y1 (strict). Selected button = lowest-index hit.
- Debounce:
  - The hold counter counts while the selected button is unchanged and valid.
  - The counter resets to 0 on release or when the selected button changes.
  - When the counter reaches HOLD_CYCLES-1, btn_press[sel] pulses for 1 cycle. The detector is then disarmed and gives no further pulse until touch_valid=0 or the selection changes (no auto-repeat).
  - Latency from first valid hit cycle to pulse is HOLD_CYCLES cycles.
- FSM transitions take effect the cycle after the btn_press pulse, so state changes exactly 1 cycle after the pulse:
  - MENU: btn0 -> GAME. Load timer=GAME_SECS, clear prescaler, pulse round_start. Other buttons are ignored.
  - GAME:
    - game_end_req -> OVER. This has priority over any same-cycle press or tick.
    - Otherwise btn1 -> PAUSE.
    - Otherwise the prescaler counts 0..TICKS_PER_SEC-1 and wraps. On wrap, sec_tick pulses and the timer decrements.
    - A tick with timer==1 sets timer to 0 and moves to OVER in the same update.
  - PAUSE: prescaler and timer are frozen, no sec_tick. btn1 -> GAME (resume, prescaler continues from its frozen value, no round_start). btn2 -> MENU. game_end_req is ignored.
  - OVER: timer holds its final value. btn0 -> GAME (restart, reload as from MENU, round_start pulses). btn2 -> MENU.
  - Entering MENU reloads timer=GAME_SECS.
- btn_press always reports accepted presses, including buttons ignored by the FSM in the current state.
- Width rules:
  - Prescaler width is $clog2(TICKS_PER_SEC).
  - Hold counter width is $clog2(HOLD_CYCLES+1).
  - Timer arithmetic never underflows; 0 is terminal.

Decomposition:
- Shared package/header holds:
  - state encodings STATE_MENU/GAME/PAUSE/OVER
  - button index constants BTN_START=0, BTN_PAUSE=1, BTN_QUIT=2
  - the rect-field extraction macro
- One sub-module, touch_btn_detect, contains the hit-test, lowest-index select, hold counter and arm logic (parameters COORD_W, N_BTN, BTN_RECT, HOLD_CYCLES). game_flow_ctrl instantiates it and owns the FSM, prescaler and timer.

Test Plan:
Bench parameters: TICKS_PER_SEC=10, GAME_SECS=3, HOLD_CYCLES=4, btn0 rect (10,10,50,30), btn1 (60,10,100,30), btn2 (110,10,150,30).

- Debounce: touch (20,20) held for 3 cycles then released -> no pulse. Hold 20 cycles -> btn_press[0] pulses once, in cycle 4. state=GAME one cycle later, round_start=1 for 1 cycle, timer=3.
- Edge of rect: touch exactly at (10,20) or (50,20) -> never pulses (strict bounds). Overlapping rects -> lower index reported.
- Countdown: in GAME with no input -> sec_tick every 10 cycles, timer 3->2->1->0. state=OVER on the 30th cycle after round_start. No further ticks; timer stays 0.
- Pause: btn1 press at prescaler=6, timer=2 -> PAUSE, timer and prescaler frozen for 100 cycles. btn1 again -> GAME, next sec_tick after 4 more cycles.
- Priority: game_end_req and btn1 pulse in the same GAME cycle -> OVER, not PAUSE. game_end_req in PAUSE -> stays PAUSE.
- Reset: assert rst mid-GAME with timer=1 -> next cycle state=MENU, timer=3, all pulses 0. A touch held across reset release -> pulse only after 4 fresh hold cycles.
